// File: rtl/bqm_sensor_conditioner.sv
// Queue sensor conditioner: synchronises and debounces the departure (inA) and
// arrival (inB) sensors into single-clk count pulses, with stuck-sensor flags.

module bqm_debounce_channel #(
   parameter int DEBOUNCE_TICKS = 10,
   parameter int STUCK_TICKS    = 5000
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic s,
   output logic press,
   output logic stuck
);

   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HW = $clog2(STUCK_TICKS + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(STUCK_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(STUCK_TICKS);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      PRESSED,
      REL,
      STUCK
   } state_t;

   state_t        state;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hcnt;

   // NOTE: state registers use non-blocking assignments only, so every branch
   // below reads the values held before this edge regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         dcnt  <= '0;
         hcnt  <= '0;
         press <= 1'b0;
         stuck <= 1'b0;
      end else begin
         // NOTE: default-low strobe; a branch that accepts a press overrides it,
         // so press is high for exactly the one clk after the accepting tick.
         press <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (s) begin
                     if (DEBOUNCE_TICKS == 1) begin
                        state <= PRESSED;
                        dcnt  <= '0;
                        hcnt  <= '0;
                        press <= 1'b1;
                     end else begin
                        state <= ARM;
                        dcnt  <= DW'(1);
                     end
                  end
               end

               ARM: begin
                  if (s) begin
                     if (dcnt == DB_LAST) begin
                        state <= PRESSED;
                        dcnt  <= '0;
                        hcnt  <= '0;
                        press <= 1'b1;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end else begin
                     state <= IDLE;
                     dcnt  <= '0;
                  end
               end

               PRESSED: begin
                  if (s) begin
                     if (hcnt == HOLD_LAST) begin
                        state <= STUCK;
                        hcnt  <= HOLD_MAX;
                        dcnt  <= '0;
                        stuck <= 1'b1;
                     end else if (hcnt != HOLD_MAX) begin
                        hcnt <= hcnt + HW'(1);
                     end
                  end else if (DEBOUNCE_TICKS == 1) begin
                     state <= IDLE;
                     dcnt  <= '0;
                  end else begin
                     state <= REL;
                     dcnt  <= DW'(1);
                  end
               end

               // A bounce back to high resumes the hold without a new event.
               REL: begin
                  if (!s) begin
                     if (dcnt == DB_LAST) begin
                        state <= IDLE;
                        dcnt  <= '0;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end else begin
                     state <= PRESSED;
                     dcnt  <= '0;
                  end
               end

               STUCK: begin
                  if (!s) begin
                     if (dcnt == DB_LAST) begin
                        state <= IDLE;
                        dcnt  <= '0;
                        stuck <= 1'b0;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end else begin
                     dcnt <= '0;
                  end
               end

               default: begin
                  state <= IDLE;
                  dcnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

module bqm_sensor_conditioner #(
   parameter int TICK_DIV       = 50_000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int STUCK_TICKS    = 5000
) (
   input  logic clk,
   input  logic reset,
   input  logic inA,
   input  logic inB,
   output logic down_pulse,
   output logic up_pulse,
   output logic stuck_a,
   output logic stuck_b
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [1:0]    sync_a;
   logic [1:0]    sync_b;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          press_a;
   logic          press_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a   <= '0;
         sync_b   <= '0;
         tick_cnt <= '0;
      end else begin
         sync_a   <= {sync_a[0], inA};
         sync_b   <= {sync_b[0], inB};
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   bqm_debounce_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .STUCK_TICKS    (STUCK_TICKS)
   ) u_chan_a (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .s     (sync_a[1]),
      .press (press_a),
      .stuck (stuck_a)
   );

   bqm_debounce_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .STUCK_TICKS    (STUCK_TICKS)
   ) u_chan_b (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .s     (sync_b[1]),
      .press (press_b),
      .stuck (stuck_b)
   );

   // An arrival and a departure accepted on the same tick cancel out.
   assign down_pulse = press_a & ~press_b;
   assign up_pulse   = press_b & ~press_a;

endmodule

// File: tb/tb_bqm_sensor_conditioner.sv
// Self-checking bench for bqm_sensor_conditioner: expected pulse cycles are
// queued when stimulus is driven and matched against the outputs every clk.

module tb_bqm_sensor_conditioner;

   localparam int TICK_DIV       = 4;
   localparam int DEBOUNCE_TICKS = 3;
   localparam int STUCK_TICKS    = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic inA   = 1'b0;
   logic inB   = 1'b0;
   logic down_pulse;
   logic up_pulse;
   logic stuck_a;
   logic stuck_b;

   int cyc         = 0;
   int vectors     = 0;
   int miscompares = 0;
   int exp_down[$];
   int exp_up[$];
   int sa_on       = 0;
   int sa_off      = 0;

   bqm_sensor_conditioner #(
      .TICK_DIV       (TICK_DIV),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .STUCK_TICKS    (STUCK_TICKS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .inA        (inA),
      .inB        (inB),
      .down_pulse (down_pulse),
      .up_pulse   (up_pulse),
      .stuck_a    (stuck_a),
      .stuck_b    (stuck_b)
   );

   always #5 clk = ~clk;

   // Level first captured at clk p is seen by the FSM two clks later, and
   // ticks update the FSM on clks that are multiples of TICK_DIV.
   function automatic int first_tick(input int p);
      return ((p + 2 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
   endfunction

   function automatic int accept_at(input int p);
      return first_tick(p) + (DEBOUNCE_TICKS - 1) * TICK_DIV;
   endfunction

   // One clk: drive at negedge, sample at the next negedge, score all outputs.
   task automatic cycle(input logic a, input logic b);
      logic exp_d;
      logic exp_u;
      logic exp_sa;
      inA = a;
      inB = b;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      exp_d = 1'b0;
      exp_u = 1'b0;
      if (exp_down.size() > 0 && exp_down[0] == cyc) begin
         exp_d = 1'b1;
         void'(exp_down.pop_front());
      end
      if (exp_up.size() > 0 && exp_up[0] == cyc) begin
         exp_u = 1'b1;
         void'(exp_up.pop_front());
      end
      exp_sa = (cyc >= sa_on) && (cyc < sa_off);
      vectors += 4;
      if (down_pulse !== exp_d) begin
         miscompares++;
         $display("FAIL down_pulse cyc=%0d got=%b exp=%b", cyc, down_pulse, exp_d);
      end
      if (up_pulse !== exp_u) begin
         miscompares++;
         $display("FAIL up_pulse cyc=%0d got=%b exp=%b", cyc, up_pulse, exp_u);
      end
      if (stuck_a !== exp_sa) begin
         miscompares++;
         $display("FAIL stuck_a cyc=%0d got=%b exp=%b", cyc, stuck_a, exp_sa);
      end
      if (stuck_b !== 1'b0) begin
         miscompares++;
         $display("FAIL stuck_b cyc=%0d got=%b exp=0", cyc, stuck_b);
      end
   endtask

   task automatic drive(input logic a, input logic b, input int n);
      for (int i = 0; i < n; i++) cycle(a, b);
   endtask

   task automatic settle();
      drive(1'b0, 1'b0, 24);
   endtask

   task automatic do_reset(input logic a, input logic b, input int n);
      inA   = a;
      inB   = b;
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if ({down_pulse, up_pulse, stuck_a, stuck_b} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {down_pulse, up_pulse, stuck_a, stuck_b});
         end
      end
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1, 4);
      drive(1'b1, 1'b1, 16);
      settle();
      do_reset(1'b0, 1'b1, 4);
      exp_up.push_back(accept_at(1));
      drive(1'b0, 1'b1, 16);
      settle();
      vectors++;
      if (exp_up.size() != 0 || exp_down.size() != 0) begin
         miscompares++;
         $display("FAIL reset_pending got=%0d exp=0", exp_up.size() + exp_down.size());
      end
   endtask

   task automatic test_glitch();
      int p;
      drive(1'b0, 1'b1, 2 * TICK_DIV);
      settle();
      p = cyc + 1;
      exp_up.push_back(accept_at(p));
      drive(1'b0, 1'b1, DEBOUNCE_TICKS * TICK_DIV);
      settle();
      vectors++;
      if (exp_up.size() != 0) begin
         miscompares++;
         $display("FAIL glitch_pending got=%0d exp=0", exp_up.size());
      end
   endtask

   task automatic test_back_to_back();
      int p;
      p = cyc + 1;
      exp_up.push_back(accept_at(p));
      exp_up.push_back(accept_at(p + 40));
      drive(1'b0, 1'b1, 20);
      drive(1'b0, 1'b0, 20);
      drive(1'b0, 1'b1, 20);
      settle();
      vectors++;
      if (exp_up.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_pending got=%0d exp=0", exp_up.size());
      end
   endtask

   task automatic test_simultaneous();
      int p;
      drive(1'b1, 1'b1, 20);
      settle();
      p = cyc + 1;
      exp_down.push_back(accept_at(p));
      drive(1'b1, 1'b0, 20);
      settle();
      p = cyc + 1;
      exp_down.push_back(accept_at(p));
      exp_up.push_back(accept_at(p + TICK_DIV));
      drive(1'b1, 1'b0, TICK_DIV);
      drive(1'b1, 1'b1, 16);
      settle();
      vectors++;
      if (exp_up.size() != 0 || exp_down.size() != 0) begin
         miscompares++;
         $display("FAIL simul_pending got=%0d exp=0", exp_up.size() + exp_down.size());
      end
   endtask

   task automatic test_stuck();
      int p;
      int acc;
      p   = cyc + 1;
      acc = accept_at(p);
      exp_down.push_back(acc);
      sa_on  = acc + STUCK_TICKS * TICK_DIV;
      sa_off = sa_on + 1000;
      while (cyc < sa_on + 3 * TICK_DIV) cycle(1'b1, 1'b0);
      p      = cyc + 1;
      sa_off = accept_at(p);
      while (cyc < sa_off + TICK_DIV) cycle(1'b0, 1'b0);
      sa_on  = 0;
      sa_off = 0;
      settle();
      vectors++;
      if (exp_down.size() != 0) begin
         miscompares++;
         $display("FAIL stuck_pending got=%0d exp=0", exp_down.size());
      end
   endtask

   task automatic test_release_bounce();
      int p;
      p = cyc + 1;
      exp_down.push_back(accept_at(p));
      drive(1'b1, 1'b0, 16);
      for (int g = 0; g < 2; g++) begin
         drive(1'b0, 1'b0, TICK_DIV);
         drive(1'b1, 1'b0, 2 * TICK_DIV);
      end
      settle();
      // Two accepted samples into ARM, then reset must discard them.
      drive(1'b1, 1'b0, 10);
      do_reset(1'b0, 1'b0, 3);
      drive(1'b0, 1'b0, 8);
      p = cyc + 1;
      exp_down.push_back(accept_at(p));
      drive(1'b1, 1'b0, DEBOUNCE_TICKS * TICK_DIV);
      settle();
      vectors++;
      if (exp_down.size() != 0) begin
         miscompares++;
         $display("FAIL bounce_pending got=%0d exp=0", exp_down.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_glitch();
      test_back_to_back();
      test_simultaneous();
      test_stuck();
      test_release_bounce();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
